// File: rtl/irq_timer_pkg.sv
// Shared constants for the memory-mapped countdown timer (irq_timer).
// Holds register offsets, CTRL bit positions, MODE encodings and FSM states.
// Optional macro TIMER_PRESCALER_EN adds the CTRL[7:4] prescaler field position.
package irq_timer_pkg;

    // Word offsets decoded from bus address bits [3:2]
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    // CTRL register layout
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;
`ifdef TIMER_PRESCALER_EN
    localparam int CTRL_PS_LSB   = 4;
`endif

    // Only auto-reload is decoded; every other MODE value behaves as one-shot.
    localparam logic [1:0] MODE_AUTO = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

endpackage

// File: rtl/irq_timer_if.sv
// Bus-side signal bundle of the timer: address/strobe/data in, read data and IRQ out.
// Ports: Addr[1:0], We, DIn[31:0] from the bridge; DOut[31:0], IRQ back from the timer.
// master modport = bridge/testbench side, slave modport = timer side.
interface irq_timer_if;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    modport master (output Addr, We, DIn, input DOut, IRQ);
    modport slave  (input Addr, We, DIn, output DOut, IRQ);
endinterface

// File: rtl/irq_timer_prescaler.sv
// Prescaler for the timer: 16-bit free-running counter plus tick generator.
// Ports: clk, rst_n, clr_i (synchronous clear), ps_i (log2 divide), tick_o.
// tick_o is high one cycle in every 2^ps_i; the first tick after a clear is 2^ps_i cycles later.
module irq_timer_prescaler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic [3:0] ps_i,
    output logic       tick_o
);
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] mask;

    always_comb begin
        mask   = (16'd1 << ps_i) - 16'd1;
        cnt_d  = clr_i ? 16'd0 : cnt_q + 16'd1;
        // Tick when the low ps_i bits are all ones, i.e. just before they wrap.
        tick_o = ((cnt_q & mask) == mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/irq_timer.sv
// Programmable countdown timer on the system bridge, driving one CP0 HWInt line.
// Ports: clk, rst_n (async active-low), bus (slave: Addr/We/DIn in, DOut/IRQ out).
// Optional macro TIMER_PRESCALER_EN enables CTRL[7:4]=PS, decrementing every 2^PS cycles.
module irq_timer
    import irq_timer_pkg::*;
#(
    parameter int          CNT_W    = 32,
    parameter logic [31:0] CTRL_RST = 32'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    irq_timer_if.slave bus
);
    state_e             state_q, state_d;
    logic               en_q, en_d;
    logic [1:0]         mode_q, mode_d;
    logic               im_q, im_d;
    logic               irq_flag_q, irq_flag_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               tick;
    logic               wr_ctrl, wr_preset;
    logic [31:0]        ctrl_rd, preset_rd, count_rd;

`ifdef TIMER_PRESCALER_EN
    logic [3:0]         ps_q, ps_d;

    // Prescaler phase restarts whenever a count (re)starts.
    irq_timer_prescaler u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  ((state_q == ST_IDLE) || (state_q == ST_LOAD)),
        .ps_i   (ps_q),
        .tick_o (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign wr_ctrl   = bus.We && (bus.Addr == OFF_CTRL);
    assign wr_preset = bus.We && (bus.Addr == OFF_PRESET);

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        mode_d     = mode_q;
        im_d       = im_q;
        irq_flag_d = irq_flag_q;
        preset_d   = preset_q;
        count_d    = count_q;
`ifdef TIMER_PRESCALER_EN
        ps_d       = ps_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (en_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d    = preset_q;
                irq_flag_d = 1'b0;
                state_d    = ST_CNT;
            end
            ST_CNT: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    // COUNT<=1 expires so that PRESET=0 behaves like PRESET=1.
                    if (count_q > CNT_W'(1)) begin
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        count_d    = '0;
                        irq_flag_d = 1'b1;
                        state_d    = ST_INT;
                    end
                end
            end
            ST_INT: begin
                if (mode_q == MODE_AUTO) begin
                    irq_flag_d = 1'b0;
                    state_d    = ST_LOAD;
                end else begin
                    // One-shot: flag stays set until software writes CTRL/PRESET.
                    en_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus writes come last so they win over the FSM (EN clear in INT, flag set).
        if (wr_ctrl) begin
            en_d       = bus.DIn[CTRL_EN_BIT];
            mode_d     = bus.DIn[CTRL_MODE_LSB +: 2];
            im_d       = bus.DIn[CTRL_IM_BIT];
`ifdef TIMER_PRESCALER_EN
            ps_d       = bus.DIn[CTRL_PS_LSB +: 4];
`endif
            irq_flag_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d   = bus.DIn[CNT_W-1:0];
            irq_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            en_q       <= CTRL_RST[CTRL_EN_BIT];
            mode_q     <= CTRL_RST[CTRL_MODE_LSB +: 2];
            im_q       <= CTRL_RST[CTRL_IM_BIT];
            irq_flag_q <= 1'b0;
            preset_q   <= '0;
            count_q    <= '0;
`ifdef TIMER_PRESCALER_EN
            ps_q       <= CTRL_RST[CTRL_PS_LSB +: 4];
`endif
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            irq_flag_q <= irq_flag_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
`ifdef TIMER_PRESCALER_EN
            ps_q       <= ps_d;
`endif
        end
    end

    // Read path: narrower registers are zero-extended, unused CTRL bits read 0.
    always_comb begin
        ctrl_rd                          = '0;
        ctrl_rd[CTRL_EN_BIT]             = en_q;
        ctrl_rd[CTRL_MODE_LSB +: 2]      = mode_q;
        ctrl_rd[CTRL_IM_BIT]             = im_q;
`ifdef TIMER_PRESCALER_EN
        ctrl_rd[CTRL_PS_LSB +: 4]        = ps_q;
`endif
        preset_rd                        = '0;
        preset_rd[CNT_W-1:0]             = preset_q;
        count_rd                         = '0;
        count_rd[CNT_W-1:0]              = count_q;

        case (bus.Addr)
            OFF_CTRL:   bus.DOut = ctrl_rd;
            OFF_PRESET: bus.DOut = preset_rd;
            OFF_COUNT:  bus.DOut = count_rd;
            OFF_RSVD:   bus.DOut = 32'h0;
            default:    bus.DOut = 32'h0;
        endcase
    end

    assign bus.IRQ = irq_flag_q & im_q;

endmodule

// File: tb/tb_irq_timer.sv
// Directed testbench for irq_timer: register table plus hand-written timing sequences.
// Inputs change 1 time unit after a rising edge; outputs are sampled before the next edge.
// Edge numbering in comments: "edge 0" is the edge that performs the CTRL write.
module tb_irq_timer;
    import irq_timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] d;
    int          hi;

    irq_timer_if bus();

    irq_timer #(.CNT_W(32), .CTRL_RST(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [1:0]  rd_addr;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[8];

`ifdef TIMER_PRESCALER_EN
    localparam logic [31:0] EXP_CTRL_ALL = 32'h0000_00F6;
`else
    localparam logic [31:0] EXP_CTRL_ALL = 32'h0000_0006;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        bus.Addr = a;
        bus.We   = 1'b1;
        bus.DIn  = v;
        @(posedge clk);
        #1;
        bus.We   = 1'b0;
        bus.DIn  = 32'h0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bus.Addr = a;
        #1;
        v = bus.DOut;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        bus.Addr = 2'd0;
        bus.We   = 1'b0;
        bus.DIn  = 32'h0;

        vecs[0] = '{1'b1, OFF_PRESET, 32'h1234_5678, OFF_PRESET, 32'h1234_5678, 1'b0};
        vecs[1] = '{1'b1, OFF_CTRL,   32'hFFFF_FFF6, OFF_CTRL,   EXP_CTRL_ALL,  1'b0};
        vecs[2] = '{1'b1, OFF_CTRL,   32'h0000_0008, OFF_CTRL,   32'h0000_0008, 1'b0};
        vecs[3] = '{1'b1, OFF_COUNT,  32'h0000_00FF, OFF_COUNT,  32'h0000_0000, 1'b0};
        vecs[4] = '{1'b1, OFF_RSVD,   32'hFFFF_FFFF, OFF_RSVD,   32'h0000_0000, 1'b0};
        vecs[5] = '{1'b0, OFF_CTRL,   32'h0000_0000, OFF_PRESET, 32'h1234_5678, 1'b0};
        vecs[6] = '{1'b1, OFF_PRESET, 32'h0000_0000, OFF_PRESET, 32'h0000_0000, 1'b0};
        vecs[7] = '{1'b0, OFF_CTRL,   32'h0000_0000, OFF_CTRL,   32'h0000_0008, 1'b0};

        // Reset values while reset is held
        step(2);
        rd(OFF_CTRL, d);   check("rst_ctrl", d, 32'h0);
        rd(OFF_PRESET, d); check("rst_preset", d, 32'h0);
        rd(OFF_COUNT, d);  check("rst_count", d, 32'h0);
        check("rst_irq", 32'(bus.IRQ), 32'h0);
        rst_n = 1'b1;
        step(1);

        // Register access table (EN stays 0, so nothing counts)
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].din);
            else            step(1);
            rd(vecs[i].rd_addr, d);
            check($sformatf("vec%0d_dout", i), d, vecs[i].exp_dout);
            check($sformatf("vec%0d_irq", i), 32'(bus.IRQ), 32'(vecs[i].exp_irq));
        end

        // Asynchronous reset mid-count at COUNT=7
        apply_reset();
        wr(OFF_PRESET, 32'd10);
        wr(OFF_CTRL, 32'h9);
        step(5);
        rd(OFF_COUNT, d); check("arst_pre_count", d, 32'd7);
        rst_n = 1'b0;
        #1;
        check("arst_irq", 32'(bus.IRQ), 32'h0);
        rd(OFF_COUNT, d); check("arst_count", d, 32'h0);
        rd(OFF_CTRL, d);  check("arst_ctrl", d, 32'h0);
        rst_n = 1'b1;
        step(3);
        rd(OFF_COUNT, d); check("arst_no_resume", d, 32'h0);

        // One-shot: PRESET=5, IRQ after edge 7, held until a CTRL write
        apply_reset();
        wr(OFF_PRESET, 32'd5);
        wr(OFF_CTRL, 32'h9);
        step(6);
        check("os_irq_e6", 32'(bus.IRQ), 32'h0);
        rd(OFF_COUNT, d); check("os_count_e6", d, 32'd1);
        step(1);
        check("os_irq_e7", 32'(bus.IRQ), 32'h1);
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (bus.IRQ) hi++;
        end
        check("os_hold20", 32'(hi), 32'd20);
        rd(OFF_CTRL, d); check("os_ctrl_en_clr", d, 32'h8);
        wr(OFF_CTRL, 32'h8);
        check("os_ack", 32'(bus.IRQ), 32'h0);

        // Auto-reload: PRESET=3, pulse every 5 cycles, COUNT 3,2,1 between
        apply_reset();
        wr(OFF_PRESET, 32'd3);
        wr(OFF_CTRL, 32'hB);
        for (int k = 1; k <= 20; k++) begin
            step(1);
            check($sformatf("ar_irq_e%0d", k), 32'(bus.IRQ), (k % 5 == 0) ? 32'h1 : 32'h0);
            rd(OFF_COUNT, d);
            check($sformatf("ar_cnt_e%0d", k), d,
                  ((k % 5) >= 2) ? 32'(5 - (k % 5)) : 32'h0);
        end
        wr(OFF_CTRL, 32'h0);

        // Mask: flag sets with IM=0, then a CTRL write clears it
        apply_reset();
        wr(OFF_PRESET, 32'd2);
        wr(OFF_CTRL, 32'h1);
        step(4);
        check("mask_flag", 32'(dut.irq_flag_q), 32'h1);
        check("mask_irq", 32'(bus.IRQ), 32'h0);
        step(2);
        wr(OFF_CTRL, 32'h8);
        check("mask_flag_clr", 32'(dut.irq_flag_q), 32'h0);
        check("mask_irq_after", 32'(bus.IRQ), 32'h0);

        // PRESET write mid-count does not disturb the running count
        apply_reset();
        wr(OFF_PRESET, 32'd10);
        wr(OFF_CTRL, 32'h9);
        step(6);
        rd(OFF_COUNT, d); check("mid_count6", d, 32'd6);
        wr(OFF_PRESET, 32'd2);
        rd(OFF_COUNT, d); check("mid_count5", d, 32'd5);
        rd(OFF_PRESET, d); check("mid_preset", d, 32'd2);
        step(4);
        check("mid_irq_e11", 32'(bus.IRQ), 32'h0);
        step(1);
        check("mid_irq_e12", 32'(bus.IRQ), 32'h1);

        // EN=0 mid-count halts at COUNT=4, re-enable reloads
        apply_reset();
        wr(OFF_PRESET, 32'd10);
        wr(OFF_CTRL, 32'h9);
        step(7);
        wr(OFF_CTRL, 32'h8);
        step(1);
        check("halt_state", 32'(dut.state_q), 32'(ST_IDLE));
        rd(OFF_COUNT, d); check("halt_count", d, 32'd4);
        step(10);
        rd(OFF_COUNT, d); check("halt_count_hold", d, 32'd4);
        check("halt_irq", 32'(bus.IRQ), 32'h0);
        wr(OFF_CTRL, 32'h9);
        step(2);
        rd(OFF_COUNT, d); check("reen_reload", d, 32'd10);

        // PRESET=0 behaves like PRESET=1
        apply_reset();
        wr(OFF_PRESET, 32'd0);
        wr(OFF_CTRL, 32'h9);
        step(2);
        check("p0_irq_e2", 32'(bus.IRQ), 32'h0);
        step(1);
        check("p0_irq_e3", 32'(bus.IRQ), 32'h1);

        // Prescaler field
        apply_reset();
        wr(OFF_PRESET, 32'd2);
        wr(OFF_CTRL, 32'h29);
`ifdef TIMER_PRESCALER_EN
        rd(OFF_CTRL, d); check("ps_ctrl", d, 32'h29);
        step(9);
        check("ps_irq_e9", 32'(bus.IRQ), 32'h0);
        step(1);
        check("ps_irq_e10", 32'(bus.IRQ), 32'h1);
`else
        rd(OFF_CTRL, d); check("ps_ctrl", d, 32'h9);
        step(3);
        check("ps_irq_e3", 32'(bus.IRQ), 32'h0);
        step(1);
        check("ps_irq_e4", 32'(bus.IRQ), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/irq_timer.md
Name: irq_timer

Overview:
Memory-mapped programmable countdown timer on the system bridge. It is the interrupt source feeding one CP0 HWInt line, normally HWInt[2].
- Software programs PRESET and CTRL with sw/lw; the block counts down and raises IRQ at expiry.
- Two modes: one-shot (IRQ held until software acknowledges) and auto-reload (one-cycle IRQ pulse per period).

Parameters:
CNT_W, 32, counter/PRESET width; values narrower than 32 are zero-extended on DOut.
CTRL_RST, 32'h0, reset value of CTRL.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
Addr  input  2  word offset [3:2]: 0=CTRL, 1=PRESET, 2=COUNT (read-only), 3=reserved
We  input  1  bus write strobe, sampled on rising clk
DIn  input  32  bus write data
DOut  output  32  combinational read data for Addr
IRQ  output  1  interrupt request to CP0 HWInt

Behaviour:
- Reset and clock: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: CTRL=CTRL_RST, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, IRQ=0, DOut reflects the reset registers.
- CTRL bits:
  - [0] EN, count enable.
  - [2:1] MODE: 00 one-shot, 01 auto-reload; 10 and 11 behave as 00.
  - [3] IM, interrupt mask.
  - [31:4] read 0.
- IRQ = irq_flag & IM. It is purely combinational from registers.
- FSM states IDLE, LOAD, CNT, INT. Actions occur on the edge that leaves a state.
  - IDLE: EN=1 -> LOAD; otherwise stay.
  - LOAD: COUNT<=PRESET, irq_flag<=0 -> CNT.
  - CNT, EN=0: -> IDLE, COUNT holds.
  - CNT, COUNT>1: COUNT<=COUNT-1, stay.
  - CNT, COUNT<=1: COUNT<=0, irq_flag<=1 -> INT.
  - INT, MODE=01: irq_flag<=0 -> LOAD.
  - INT, otherwise: EN<=0, irq_flag holds -> IDLE.
- Latency: CTRL write with EN=1 on edge T0 -> LOAD after T1 -> CNT with COUNT=P after T2 -> INT with IRQ=1 after edge T0+P+2 (P>=1). P=0 behaves as P=1.
- Auto-reload period is P+2 cycles. IRQ is high exactly 1 cycle per period.
- One-shot IRQ stays high until acknowledged. A write to CTRL or PRESET clears irq_flag on that edge.
- Bus writes:
  - A write to CTRL or PRESET takes effect on the same edge.
  - A CTRL write has priority over the INT-state EN<=0 update.
  - A PRESET write during CNT does not change COUNT; it applies at the next LOAD.
  - Writes to COUNT or reserved offsets are ignored.
- A CTRL write with EN=0 during CNT halts the count next edge (-> IDLE). Re-enabling reloads from PRESET; there is no resume.
- Reading the reserved offset returns 0.
- rst_n asserted in any state returns immediately to reset values. There is no partial count after release.

Optional Feature:
Macro TIMER_PRESCALER_EN.
- Defined: CTRL[7:4]=PS (reset 0), read/write. In CNT, the decrement and expiry check occur only on prescaler ticks, every 2^PS clk cycles. The prescaler is cleared in LOAD and IDLE.
- Undefined: a tick occurs every cycle, CTRL[7:4] reads 0, and writes to those bits are ignored.

Decomposition:
- Shared constants header (the timer's package, alongside the CP0 constants):
  - register offsets
  - CTRL bit positions
  - MODE encodings
  - FSM state encodings
- One natural sub-module, timer_prescaler: 16-bit free counter plus tick generator, instantiated only under TIMER_PRESCALER_EN.

Test Plan:
- Reset: drive rst_n=0 mid-count with COUNT=7 -> IRQ=0, COUNT=0, CTRL=0 immediately, without waiting for clk.
- One-shot: PRESET=5, then CTRL=0x9 (EN, mode 0, IM) at edge 0 -> IRQ rises after edge 7; stays high 20 cycles; CTRL reads 0x8; a CTRL write of 0x8 drops IRQ next edge.
- Auto-reload: PRESET=3, CTRL=0xB -> IRQ one-cycle pulses with exactly 5-cycle spacing over 4 periods; COUNT reads 3,2,1,0 between pulses.
- Mask: PRESET=2, CTRL=0x1 -> internal flag sets but IRQ=0. Then write CTRL=0x8 with no EN -> IRQ stays 0, because the flag is cleared by the write.
- Mid-count changes:
  - PRESET=10, EN; write PRESET=2 at COUNT=6 -> expiry still follows the 10 count.
  - CTRL write EN=0 at COUNT=4 -> state IDLE, COUNT holds 4, no IRQ.
- Prescaler (TIMER_PRESCALER_EN): PRESET=2, PS=2, CTRL=0x29 -> IRQ after 2+2*4 cycles ±1 tick-phase; without the macro, CTRL reads 0x9.
